// File: rtl/ram_pkg.sv
// Shared constants for the dual-port RAM: collision-mode encodings and legal
// read-latency bounds.
package ram_pkg;

   localparam int RAM_READ_FIRST  = 0;
   localparam int RAM_WRITE_FIRST = 1;
   localparam int RAM_MIN_LAT     = 1;
   localparam int RAM_MAX_LAT     = 4;

   function automatic bit ram_lat_legal(input int lat);
      return (lat >= RAM_MIN_LAT) && (lat <= RAM_MAX_LAT);
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data delay line: STAGES registers of {valid, data}. Each data stage
// captures only on valid, so the final stage holds the last delivered word.
module ram_rd_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   output logic             dn_valid,
   output logic [WIDTH-1:0] dn_data
);

   generate
      if (STAGES == 0) begin : g_bypass
         logic unused_pipe_s;
         assign unused_pipe_s = &{1'b0, clk, rst_n};
         assign dn_valid = up_valid;
         assign dn_data  = up_data;
      end else begin : g_stages
         logic [STAGES-1:0]            vld_r;
         logic [STAGES-1:0][WIDTH-1:0] dat_r;

         // Shift valid every cycle; advance data only alongside a valid token.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_r <= '0;
               dat_r <= '0;
            end else begin
               vld_r[0] <= up_valid;
               if (up_valid) begin
                  dat_r[0] <= up_data;
               end
               for (int i = 1; i < STAGES; i++) begin
                  vld_r[i] <= vld_r[i-1];
                  if (vld_r[i-1]) begin
                     dat_r[i] <= dat_r[i-1];
                  end
               end
            end
         end

         assign dn_valid = vld_r[STAGES-1];
         assign dn_data  = dat_r[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/dual_port_ram.sv
// Synchronous RAM: port A read/write with byte lanes, port B read-only,
// pipelined reads with per-port valid and selectable collision behaviour.
module dual_port_ram
   import ram_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int BYTE_WIDTH   = 8,
   parameter int READ_LATENCY = 1,
   parameter int WRITE_MODE   = 0,
   parameter     TAG          = "DPRAM",
   localparam int NB          = WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  a_re,
   input  logic                  a_we,
   input  logic [NB-1:0]         a_be,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [WIDTH-1:0]      a_din,
   output logic [WIDTH-1:0]      a_dout,
   output logic                  a_valid,
   input  logic                  b_re,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   output logic [WIDTH-1:0]      b_dout,
   output logic                  b_valid
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   generate
      if (WIDTH % BYTE_WIDTH != 0) begin : g_err_width
         $error("dual_port_ram: WIDTH must be a multiple of BYTE_WIDTH");
      end
      if (!ram_lat_legal(READ_LATENCY)) begin : g_err_lat
         $error("dual_port_ram: READ_LATENCY out of range 1..4");
      end
      if (WRITE_MODE > RAM_WRITE_FIRST || WRITE_MODE < RAM_READ_FIRST) begin : g_err_mode
         $error("dual_port_ram: WRITE_MODE must be 0 or 1");
      end
      if ($bits(TAG) == 0) begin : g_err_tag
         $error("dual_port_ram: TAG must not be empty");
      end
   endgenerate

   function automatic logic [WIDTH-1:0] merge_word(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [WIDTH-1:0] mask);
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] wmask_s;
   logic [WIDTH-1:0] a_rd_s;
   logic [WIDTH-1:0] b_rd_s;
   logic             a_v0_r;
   logic             b_v0_r;
   logic [WIDTH-1:0] a_d0_r;
   logic [WIDTH-1:0] b_d0_r;

   // Bit-level write mask; all-zero when no lane is actually written.
   always_comb begin
      wmask_s = '0;
      for (int i = 0; i < NB; i++) begin
         wmask_s[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{a_we & a_be[i]}};
      end
   end

   // Collision resolution: write-first folds the incoming lanes into the read word.
   always_comb begin
      a_rd_s = mem[a_addr];
      b_rd_s = mem[b_addr];
      if (WRITE_MODE == RAM_WRITE_FIRST) begin
         a_rd_s = merge_word(mem[a_addr], a_din, wmask_s);
         if (b_addr == a_addr) begin
            b_rd_s = merge_word(mem[b_addr], a_din, wmask_s);
         end else begin
            b_rd_s = mem[b_addr];
         end
      end else begin
         a_rd_s = mem[a_addr];
         b_rd_s = mem[b_addr];
      end
   end

   // Array write per byte lane; contents survive reset, writes during reset are dropped.
   always_ff @(posedge clk) begin
      if (res && a_we) begin
         for (int i = 0; i < NB; i++) begin
            if (a_be[i]) begin
               mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // First read stage: registered array output, held between reads.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         a_v0_r <= 1'b0;
         b_v0_r <= 1'b0;
         a_d0_r <= '0;
         b_d0_r <= '0;
      end else begin
         a_v0_r <= a_re;
         b_v0_r <= b_re;
         if (a_re) begin
            a_d0_r <= a_rd_s;
         end
         if (b_re) begin
            b_d0_r <= b_rd_s;
         end
      end
   end

   ram_rd_pipe #(.WIDTH(WIDTH), .STAGES(READ_LATENCY - 1)) u_a_pipe (
      .clk      (clk),
      .rst_n    (res),
      .up_valid (a_v0_r),
      .up_data  (a_d0_r),
      .dn_valid (a_valid),
      .dn_data  (a_dout)
   );

   ram_rd_pipe #(.WIDTH(WIDTH), .STAGES(READ_LATENCY - 1)) u_b_pipe (
      .clk      (clk),
      .rst_n    (res),
      .up_valid (b_v0_r),
      .up_data  (b_d0_r),
      .dn_valid (b_valid),
      .dn_data  (b_dout)
   );

`ifdef DEBUG_DISPLAY
   // Trace effective writes.
   always_ff @(posedge clk) begin
      if (res && a_we && (a_be != '0)) begin
         $display("[%0s] written data 0x%h (be 0x%h) to address 0x%h", TAG, a_din, a_be, a_addr);
      end
   end
`endif

endmodule
